// File: rtl/audio_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared sample type, echo FSM state encoding and saturating adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int SAMPLE_W = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_FETCH = 3'd3,
        ST_MIX   = 3'd4,
        ST_WRITE = 3'd5
    } echo_state_t;

    // Operands arrive sign-extended to 64 bits, so the sum cannot overflow
    // for any w <= 63; it is then clamped to the signed w-bit range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = a + b;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (s > mx) begin
            return mx;
        end else if (s < mn) begin
            return mn;
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/delay_ram.sv
// ============================================================================
// Module   : delay_ram
// Purpose  : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delay_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/echo_delay.sv
// ============================================================================
// Module   : echo_delay
// Purpose  : Stereo feedback echo with circular delay buffer and FIFO handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module echo_delay #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DECAY_SHIFT = 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [DATA_W-1:0] audio_in_L,
    input  logic [DATA_W-1:0] audio_in_R,
    input  logic              audio_in_available,
    input  logic              audio_out_allowed,
    output logic              read_audio_in,
    output logic              write_audio_out,
    output logic [DATA_W-1:0] audio_out_L,
    output logic [DATA_W-1:0] audio_out_R,
    output logic              busy
);

    import audio_pkg::*;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

    echo_state_t              r_state;
    echo_state_t              w_next_state;
    logic        [ADDR_W-1:0] r_clr_addr;
    logic        [ADDR_W-1:0] r_wr_ptr;
    logic        [ADDR_W-1:0] r_rd_addr;
    logic signed [DATA_W-1:0] r_x_l;
    logic signed [DATA_W-1:0] r_x_r;
    logic        [DATA_W-1:0] r_out_l;
    logic        [DATA_W-1:0] r_out_r;
    logic        [DATA_W-1:0] w_d_l;
    logic        [DATA_W-1:0] w_d_r;
    logic        [DATA_W-1:0] w_y_l;
    logic        [DATA_W-1:0] w_y_r;
    logic                     w_ram_we;
    logic                     w_ram_re;
    logic        [ADDR_W-1:0] w_ram_waddr;
    logic        [DATA_W-1:0] w_ram_wdata_l;
    logic        [DATA_W-1:0] w_ram_wdata_r;

    function automatic logic [DATA_W-1:0] mix(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] d
    );
        logic signed [63:0] s;
        s = sat_add(64'(x), 64'(d >>> DECAY_SHIFT), DATA_W);
        return DATA_W'(s);
    endfunction

    assign w_y_l = enable ? mix(r_x_l, w_d_l) : r_x_l;
    assign w_y_r = enable ? mix(r_x_r, w_d_r) : r_x_r;

    assign audio_out_L = r_out_l;
    assign audio_out_R = r_out_r;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_rd_addr  <= '0;
            r_x_l      <= '0;
            r_x_r      <= '0;
            r_out_l    <= '0;
            r_out_r    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (r_state == ST_READ) begin
                r_x_l     <= audio_in_L;
                r_x_r     <= audio_in_R;
                r_rd_addr <= r_wr_ptr - delay_len;
            end
            if (r_state == ST_MIX) begin
                r_out_l <= w_y_l;
                r_out_r <= w_y_r;
            end
            if (write_audio_out) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // The RAM write port is shared between the clear sweep and the mix write-back.
    always_comb begin
        w_next_state    = r_state;
        read_audio_in   = 1'b0;
        write_audio_out = 1'b0;
        busy            = 1'b0;
        w_ram_we        = 1'b0;
        w_ram_re        = 1'b0;
        w_ram_waddr     = r_wr_ptr;
        w_ram_wdata_l   = w_y_l;
        w_ram_wdata_r   = w_y_r;
        case (r_state)
            ST_CLEAR: begin
                busy          = 1'b1;
                w_ram_we      = 1'b1;
                w_ram_waddr   = r_clr_addr;
                w_ram_wdata_l = '0;
                w_ram_wdata_r = '0;
                if (r_clr_addr == C_LAST_ADDR) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (audio_in_available && audio_out_allowed) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                read_audio_in = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_FETCH: begin
                w_ram_re     = 1'b1;
                w_next_state = ST_MIX;
            end
            ST_MIX: begin
                w_ram_we     = 1'b1;
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                write_audio_out = audio_out_allowed;
                if (audio_out_allowed) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_l (
        .clk     (CLOCK_50),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata_l),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_addr),
        .o_rdata (w_d_l)
    );

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_r (
        .clk     (CLOCK_50),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata_r),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_addr),
        .o_rdata (w_d_r)
    );

endmodule

`default_nettype wire

// File: tb/tb_echo_delay.sv
// ============================================================================
// Module   : tb_echo_delay
// Purpose  : Self-checking bench for echo_delay against a sample-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_echo_delay;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [3:0]  delay_len;
    logic [31:0] in_l;
    logic [31:0] in_r;
    logic        avail;
    logic        allowed;
    logic        rd;
    logic        wr;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_buf_l [DEPTH];
    logic [31:0] m_buf_r [DEPTH];
    int          m_wptr;

    always #5 clk = ~clk;

    echo_delay #(
        .DATA_W      (32),
        .ADDR_W      (4),
        .DECAY_SHIFT (1)
    ) dut (
        .CLOCK_50           (clk),
        .resetn             (resetn),
        .enable             (enable),
        .delay_len          (delay_len),
        .audio_in_L         (in_l),
        .audio_in_R         (in_r),
        .audio_in_available (avail),
        .audio_out_allowed  (allowed),
        .read_audio_in      (rd),
        .write_audio_out    (wr),
        .audio_out_L        (out_l),
        .audio_out_R        (out_r),
        .busy               (busy)
    );

    // ---------------- reference model: one call per sample ----------------
    function automatic logic [31:0] model_mix(input logic [31:0] x, input logic [31:0] d,
                                              input logic en);
        longint s;
        if (!en) return x;
        s = longint'($signed(x)) + (longint'($signed(d)) >>> 1);
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return 32'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_buf_l[i] = '0;
            m_buf_r[i] = '0;
        end
        m_wptr = 0;
    endtask

    task automatic model_step(input logic [31:0] xl, input logic [31:0] xr, input logic en,
                              input logic [3:0] dly, output logic [31:0] el,
                              output logic [31:0] er);
        int idx;
        idx = (m_wptr - int'(dly) + DEPTH) % DEPTH;
        el  = model_mix(xl, m_buf_l[idx], en);
        er  = model_mix(xr, m_buf_r[idx], en);
        m_buf_l[m_wptr] = el;
        m_buf_r[m_wptr] = er;
        m_wptr = (m_wptr + 1) % DEPTH;
    endtask

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic do_reset();
        avail   = 1'b0;
        allowed = 1'b1;
        resetn  = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        model_reset();
    endtask

    task automatic run_sample(input logic [31:0] xl, input logic [31:0] xr, input logic en,
                              input logic [3:0] dly, output logic [31:0] yl,
                              output logic [31:0] yr, output int lat, output int extra_rd,
                              output bit timeout);
        int t_rd;
        timeout  = 1'b0;
        extra_rd = 0;
        lat      = -1;
        yl       = '0;
        yr       = '0;
        t_rd     = -1;
        @(posedge clk);
        #1;
        in_l = xl; in_r = xr; enable = en; delay_len = dly; avail = 1'b1; allowed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd) begin
                t_rd = i;
                break;
            end
        end
        if (t_rd < 0) begin
            timeout = 1'b1;
            avail   = 1'b0;
            return;
        end
        @(posedge clk);
        #1 avail = 1'b0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (wr) begin
                lat = i;
                yl  = out_l;
                yr  = out_r;
                break;
            end
            if (rd) extra_rd++;
        end
        if (lat < 0) timeout = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int nb;
        int bad;
        resetn = 1'b0; avail = 1'b0; allowed = 1'b1; enable = 1'b1; delay_len = '0;
        in_l = '0; in_r = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0 || out_l !== 32'h0 || out_r !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: rd=%b wr=%b L=%h R=%h busy=%b, need 0 0 0 0 1",
                     rd, wr, out_l, out_r, busy);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        avail = 1'b1;
        in_l = 32'h1234_5678; in_r = 32'h8765_4321;
        nb = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (rd !== 1'b0 || wr !== 1'b0 || out_l !== 32'h0 || out_r !== 32'h0) bad++;
        end
        avail = 1'b0;
        checks++;
        if (nb != DEPTH) begin
            errors++;
            $display("FAIL clear_length: busy cycles=%0d, need %0d", nb, DEPTH);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_quiet: %0d cycles with activity, need 0", bad);
        end
        model_reset();
    endtask

    task automatic test_bypass();
        logic [31:0] yl, yr, el, er;
        int lat, xr_cnt;
        bit to;
        run_sample(32'h0010_0000, 32'hFFF0_0000, 1'b0, 4'd3, yl, yr, lat, xr_cnt, to);
        model_step(32'h0010_0000, 32'hFFF0_0000, 1'b0, 4'd3, el, er);
        checks++;
        if (to || lat != 3) begin
            errors++;
            $display("FAIL bypass_latency: latency=%0d timeout=%0b, need 3", lat, to);
        end
        checks++;
        if (yl !== 32'h0010_0000 || yr !== er) begin
            errors++;
            $display("FAIL bypass_data: L=%h R=%h, need %h %h", yl, yr, 32'h0010_0000, er);
        end
        checks++;
        if (xr_cnt != 0) begin
            errors++;
            $display("FAIL bypass_single_read: extra reads=%0d, need 0", xr_cnt);
        end
    endtask

    task automatic test_echo_decay();
        logic [31:0] yl, yr, el, er, xl;
        logic [31:0] spec_even [4];
        int lat, xr_cnt;
        bit to;
        spec_even[0] = 32'h4000_0000; spec_even[1] = 32'h2000_0000;
        spec_even[2] = 32'h1000_0000; spec_even[3] = 32'h0800_0000;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            xl = (s == 0) ? 32'h4000_0000 : 32'h0;
            run_sample(xl, (s == 0) ? 32'hC000_0000 : 32'h0, 1'b1, 4'd2, yl, yr, lat, xr_cnt, to);
            model_step(xl, (s == 0) ? 32'hC000_0000 : 32'h0, 1'b1, 4'd2, el, er);
            checks++;
            if (to || yl !== el || yr !== er || yl !== ((s % 2 == 0 && s < 8) ? spec_even[s/2] : 32'h0)) begin
                errors++;
                $display("FAIL echo_decay[%0d]: L=%h R=%h timeout=%0b, need %h %h", s, yl, yr, to, el, er);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] yl, yr, el, er, x;
        int lat, xr_cnt;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            x = (pass == 0) ? 32'h7000_0000 : 32'h9000_0000;
            for (int s = 0; s < 2; s++) begin
                run_sample(x, ~x, 1'b1, 4'd1, yl, yr, lat, xr_cnt, to);
                model_step(x, ~x, 1'b1, 4'd1, el, er);
            end
            checks++;
            if (to || yl !== el || yr !== er || yl !== ((pass == 0) ? 32'h7FFF_FFFF : 32'h8000_0000)) begin
                errors++;
                $display("FAIL saturation[%0d]: L=%h R=%h, need %h %h", pass, yl, yr, el, er);
            end
        end
    endtask

    task automatic test_random(input int n, input bit full_delay);
        logic [31:0] yl, yr, el, er, xl, xr;
        logic [3:0] dly;
        logic en;
        int lat, xr_cnt, bad;
        bit to;
        bad = 0;
        for (int s = 0; s < n; s++) begin
            xl  = $urandom;
            xr  = $urandom;
            en  = full_delay ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            dly = full_delay ? 4'd0 : 4'($urandom_range(0, 15));
            run_sample(xl, xr, en, dly, yl, yr, lat, xr_cnt, to);
            model_step(xl, xr, en, dly, el, er);
            checks++;
            if (to || lat != 3 || xr_cnt != 0 || yl !== el || yr !== er) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random[%0d] full=%0b: L=%h R=%h lat=%0d, need %h %h lat=3",
                             s, full_delay, yl, yr, lat, el, er);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] el, er, xl, xr;
        int got_rd, n_wr, held_wr, held_rd;
        logic [31:0] yl, yr;
        xl = $urandom; xr = $urandom;
        model_step(xl, xr, 1'b1, 4'd5, el, er);
        @(posedge clk);
        #1;
        in_l = xl; in_r = xr; enable = 1'b1; delay_len = 4'd5; avail = 1'b1; allowed = 1'b1;
        got_rd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd) begin
                got_rd = 1;
                break;
            end
        end
        @(posedge clk);           // into FETCH
        @(posedge clk);           // into MIX
        #1 allowed = 1'b0;
        held_wr = 0; held_rd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr) held_wr++;
            if (rd) held_rd++;
        end
        checks++;
        if (got_rd == 0 || held_wr != 0 || held_rd != 0) begin
            errors++;
            $display("FAIL backpressure_hold: read_seen=%0d writes=%0d reads=%0d, need 1 0 0",
                     got_rd, held_wr, held_rd);
        end
        @(posedge clk);
        #1 allowed = 1'b1; avail = 1'b0;
        n_wr = 0; yl = '0; yr = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr) begin
                n_wr++;
                yl = out_l;
                yr = out_r;
            end
        end
        checks++;
        if (n_wr != 1 || yl !== el || yr !== er) begin
            errors++;
            $display("FAIL backpressure_release: writes=%0d L=%h R=%h, need 1 %h %h",
                     n_wr, yl, yr, el, er);
        end
    endtask

    task automatic test_reset_mid_sample();
        logic [31:0] yl, yr, el, er;
        int lat, xr_cnt, n_wr, nb, bad;
        bit to;
        for (int s = 0; s < DEPTH; s++) begin
            run_sample($urandom | 32'h1, $urandom | 32'h1, 1'b0, 4'd1, yl, yr, lat, xr_cnt, to);
        end
        @(posedge clk);
        #1;
        in_l = 32'h5555_5555; in_r = 32'h2AAA_AAAA; enable = 1'b1; avail = 1'b1; allowed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd) break;
        end
        @(posedge clk);           // into FETCH
        #1 resetn = 1'b0;
        avail = 1'b0;
        #1;
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0 || out_l !== 32'h0 || out_r !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_values: rd=%b wr=%b L=%h R=%h busy=%b, need 0 0 0 0 1",
                     rd, wr, out_l, out_r, busy);
        end
        n_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr) n_wr++;
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr) n_wr++;
            if (!busy) break;
            nb++;
        end
        checks++;
        if (n_wr != 0 || nb != DEPTH) begin
            errors++;
            $display("FAIL midreset_clear: writes=%0d busy cycles=%0d, need 0 %0d", n_wr, nb, DEPTH);
        end
        model_reset();
        bad = 0;
        for (int s = 0; s < DEPTH + 2; s++) begin
            delay_len = 4'($urandom_range(0, 15));
            run_sample(32'h0, 32'h0, 1'b1, delay_len, yl, yr, lat, xr_cnt, to);
            model_step(32'h0, 32'h0, 1'b1, delay_len, el, er);
            if (to || yl !== el || yr !== er) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_zero_echo: %0d non-zero or missing outputs, need 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_echo_decay();
        test_saturation();
        do_reset();
        test_random(40, 1'b0);
        test_random(24, 1'b1);
        test_backpressure();
        test_random(8, 1'b0);
        test_reset_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
